// File: rtl/fir_delay_line.sv
// Sample delay line for an FIR front end: DEPTH-tap shift register with fill tracking
// and a snapshot-based serial readout that is independent of live shifting.
module fir_delay_line #(
    parameter int WIDTH  = 3,
    parameter int DEPTH  = 40,
    parameter int GROUPS = 4
) (
    input  logic                       iClk12M,
    input  logic                       iRst,
    input  logic                       iEnSample,
    input  logic [WIDTH-1:0]           iFirIn,
    input  logic                       iFlush,
    input  logic                       iRdStart,
    output logic [DEPTH*WIDTH-1:0]     oTaps,
    output logic [DEPTH*WIDTH-1:0]     oGroupBus,
    output logic                       oShiftDone,
    output logic [$clog2(DEPTH+1)-1:0] oFillCnt,
    output logic                       oPrimed,
    output logic [WIDTH-1:0]           oRdData,
    output logic                       oRdValid,
    output logic                       oRdLast,
    output logic                       oRdBusy
);

    localparam int FW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam int GW = (DEPTH / GROUPS) * WIDTH;
    localparam logic [FW-1:0] FULL_CNT = FW'(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH % GROUPS) != 0) begin : g_bad_params
        $error("fir_delay_line: illegal DEPTH/GROUPS combination");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_e;

    rd_state_e              state_q, state_d;
    logic [DEPTH*WIDTH-1:0] taps_q, taps_d;
    logic [DEPTH*WIDTH-1:0] snap_q, snap_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   shift_done_q, shift_done_d;

    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            state_q      <= IDLE;
            taps_q       <= '0;
            snap_q       <= '0;
            fill_q       <= '0;
            idx_q        <= '0;
            shift_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            taps_q       <= taps_d;
            snap_q       <= snap_d;
            fill_q       <= fill_d;
            idx_q        <= idx_d;
            shift_done_q <= shift_done_d;
        end
    end

    // Flush wins over a same-edge strobe: no shift and no done pulse.
    always_comb begin
        taps_d       = taps_q;
        fill_d       = fill_q;
        shift_done_d = 1'b0;
        if (iFlush) begin
            taps_d = '0;
            fill_d = '0;
        end else if (iEnSample) begin
            taps_d       = {taps_q[(DEPTH-1)*WIDTH-1:0], iFirIn};
            shift_done_d = 1'b1;
            if (fill_q != FULL_CNT) begin
                fill_d = fill_q + FW'(1);
            end
        end
    end

    // Snapshot takes the pre-edge taps, so a coincident strobe is not captured.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (iRdStart) begin
                    state_d = READ;
                    snap_d  = taps_q;
                    idx_d   = '0;
                end
            end
            READ: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar g = 0; g < GROUPS; g++) begin : g_group
        assign oGroupBus[g*GW +: GW] = taps_q[g*GW +: GW];
    end

    assign oTaps      = taps_q;
    assign oShiftDone = shift_done_q;
    assign oFillCnt   = fill_q;
    assign oPrimed    = (fill_q == FULL_CNT);
    assign oRdValid   = (state_q == READ);
    assign oRdBusy    = (state_q == READ);
    assign oRdLast    = (state_q == READ) && (idx_q == LAST_IDX);
    assign oRdData    = (state_q == READ) ? snap_q[idx_q*WIDTH +: WIDTH] : '0;

endmodule

// File: tb/tb_fir_delay_line.sv
// Directed bench: default and 8x16x2 instances driven in lock-step, with a sample-history
// model for the taps and a beat queue for the snapshot readout.
module tb_fir_delay_line;

    localparam int WA = 3;
    localparam int DA = 40;
    localparam int WB = 8;
    localparam int DB = 16;

    typedef struct {
        logic [7:0] d;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, flush, rdstart;
    logic [WA-1:0] firA;
    logic [WB-1:0] firB;

    logic [DA*WA-1:0] tapsA, grpA;
    logic             shdA, primedA, rdValidA, rdLastA, rdBusyA;
    logic [5:0]       fillA;
    logic [WA-1:0]    rdDataA;

    logic [DB*WB-1:0] tapsB, grpB;
    logic             shdB, primedB, rdValidB, rdLastB, rdBusyB;
    logic [4:0]       fillB;
    logic [WB-1:0]    rdDataB;

    fir_delay_line dutA (
        .iClk12M(clk), .iRst(rst), .iEnSample(en), .iFirIn(firA), .iFlush(flush),
        .iRdStart(rdstart), .oTaps(tapsA), .oGroupBus(grpA), .oShiftDone(shdA),
        .oFillCnt(fillA), .oPrimed(primedA), .oRdData(rdDataA), .oRdValid(rdValidA),
        .oRdLast(rdLastA), .oRdBusy(rdBusyA)
    );

    fir_delay_line #(.WIDTH(WB), .DEPTH(DB), .GROUPS(2)) dutB (
        .iClk12M(clk), .iRst(rst), .iEnSample(en), .iFirIn(firB), .iFlush(flush),
        .iRdStart(rdstart), .oTaps(tapsB), .oGroupBus(grpB), .oShiftDone(shdB),
        .oFillCnt(fillB), .oPrimed(primedB), .oRdData(rdDataB), .oRdValid(rdValidB),
        .oRdLast(rdLastB), .oRdBusy(rdBusyB)
    );

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    logic [WA-1:0] histA[$];
    logic [WB-1:0] histB[$];
    beat_t         qA[$];
    beat_t         qB[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [WA-1:0] tA(int k);
        return (k < histA.size()) ? histA[k] : '0;
    endfunction

    function automatic logic [WB-1:0] tB(int k);
        return (k < histB.size()) ? histB[k] : '0;
    endfunction

    function automatic logic [DA*WA-1:0] expA();
        logic [DA*WA-1:0] v = '0;
        for (int k = 0; k < DA; k++) v[k*WA +: WA] = tA(k);
        return v;
    endfunction

    function automatic logic [DB*WB-1:0] expB();
        logic [DB*WB-1:0] v = '0;
        for (int k = 0; k < DB; k++) v[k*WB +: WB] = tB(k);
        return v;
    endfunction

    task automatic mshift();
        histA.push_front(firA);
        if (histA.size() > DA) void'(histA.pop_back());
        histB.push_front(firB);
        if (histB.size() > DB) void'(histB.pop_back());
    endtask

    task automatic mclear();
        histA.delete();
        histB.delete();
    endtask

    task automatic push_snap(input bit doA, input bit doB);
        if (doA) for (int k = 0; k < DA; k++) qA.push_back('{d: 8'(tA(k)), last: (k == DA-1)});
        if (doB) for (int k = 0; k < DB; k++) qB.push_back('{d: tB(k), last: (k == DB-1)});
    endtask

    task automatic check_state(input string tag);
        logic [DB*WB-1:0] eb;
        eb = expB();
        chk({tag, ".tapsA"}, tapsA, expA());
        chk({tag, ".groupA"}, grpA, expA());
        chk({tag, ".fillA"}, fillA, histA.size());
        chk({tag, ".primedA"}, primedA, histA.size() == DA);
        chk({tag, ".tapsB"}, tapsB, eb);
        chk({tag, ".group1B"}, grpB[DB*WB-1 -: DB*WB/2], eb[DB*WB-1 -: DB*WB/2]);
        chk({tag, ".fillB"}, fillB, histB.size());
        chk({tag, ".primedB"}, primedB, histB.size() == DB);
    endtask

    task automatic chk_shd(input string tag, input logic exp);
        chk({tag, ".shdA"}, shdA, exp);
        chk({tag, ".shdB"}, shdB, exp);
    endtask

    task automatic strobe(input logic [WA-1:0] a, input logic [WB-1:0] b, input string tag);
        en = 1'b1; firA = a; firB = b;
        mshift();
        tick();
        en = 1'b0;
        chk_shd({tag, ".pulse"}, 1'b1);
        check_state(tag);
        tick();
        chk_shd({tag, ".after"}, 1'b0);
    endtask

    // Readout is valid exactly while beats are owed; each beat is checked against the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            beat_t e;
            chk("rd.validA", rdValidA, qA.size() != 0);
            chk("rd.busyA", rdBusyA, qA.size() != 0);
            if (qA.size() != 0) begin
                e = qA.pop_front();
                chk("rd.dataA", rdDataA, e.d);
                chk("rd.lastA", rdLastA, e.last);
            end else begin
                chk("rd.idle_dataA", rdDataA, 0);
                chk("rd.idle_lastA", rdLastA, 0);
            end
            chk("rd.validB", rdValidB, qB.size() != 0);
            chk("rd.busyB", rdBusyB, qB.size() != 0);
            if (qB.size() != 0) begin
                e = qB.pop_front();
                chk("rd.dataB", rdDataB, e.d);
                chk("rd.lastB", rdLastB, e.last);
            end else begin
                chk("rd.idle_dataB", rdDataB, 0);
                chk("rd.idle_lastB", rdLastB, 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; rdstart = 1'b0; firA = '0; firB = '0;
        tick();
        tick();
        mon_en = 1'b1;
        check_state("reset");
        chk_shd("reset", 1'b0);
        rst = 1'b0;

        // Fill with the cyclic pattern 1,2,3,-4,...; tap k holds sample (40-k).
        for (int i = 1; i <= 41; i++) begin
            strobe(WA'(i), WB'(i * 37 + 1), "fill");
            if (i == 40) begin
                chk("fill40.tap39", tapsA[39*WA +: WA], 3'd1);
                chk("fill40.tap0", tapsA[0 +: WA], 3'd0);
                chk("fill40.fill", fillA, 6'd40);
            end
        end
        chk("fill41.tap39", tapsA[39*WA +: WA], 3'd2);
        chk("fill41.fill", fillA, 6'd40);

        // Plain readout of a primed line.
        rdstart = 1'b1;
        push_snap(1'b1, 1'b1);
        tick();
        rdstart = 1'b0;
        repeat (44) tick();
        chk("rd1.doneA", qA.size(), 0);
        chk("rd1.doneB", qB.size(), 0);

        // Readout started with a coincident strobe, then strobes/flush/restarts during READ.
        en = 1'b1; rdstart = 1'b1; firA = 3'd5; firB = 8'hA5;
        push_snap(1'b1, 1'b1);
        mshift();
        tick();
        en = 1'b0; rdstart = 1'b0;
        check_state("rd2.start");
        for (int k = 1; k <= 60; k++) begin
            en = 1'b0; flush = 1'b0;
            rdstart = (k == 5 || k == 16 || k == 40);
            if (k == 40) push_snap(1'b0, 1'b1);
            if (k == 20 || k == 40) begin
                en = 1'b1; firA = WA'($urandom); firB = WB'($urandom);
                mshift();
            end
            if (k == 30) begin
                flush = 1'b1;
                mclear();
            end
            tick();
            check_state("rd2.live");
        end
        en = 1'b0; flush = 1'b0; rdstart = 1'b0;
        chk("rd2.doneA", qA.size(), 0);
        chk("rd2.doneB", qB.size(), 0);

        // Flush on the same edge as a strobe.
        en = 1'b1; flush = 1'b1; firA = 3'd3; firB = 8'h55;
        tick();
        en = 1'b0; flush = 1'b0;
        mclear();
        chk_shd("flush", 1'b0);
        check_state("flush");
        tick();
        chk_shd("flush.after", 1'b0);

        // Reset during the tenth readout beat aborts the readout.
        for (int i = 1; i <= 20; i++) strobe(WA'(i + 2), WB'(i * 11), "refill");
        rdstart = 1'b1;
        push_snap(1'b1, 1'b1);
        tick();
        for (int k = 1; k <= 9; k++) begin
            rdstart = (k == 3);
            tick();
        end
        rdstart = 1'b0;
        rst = 1'b1;
        qA.delete();
        qB.delete();
        mclear();
        tick();
        check_state("rst_abort");
        chk_shd("rst_abort", 1'b0);
        rst = 1'b0;
        repeat (3) tick();
        chk("post_rst.validA", rdValidA, 1'b0);
        chk("post_rst.validB", rdValidB, 1'b0);
        check_state("post_rst");

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
